// File: rtl/pwm_breath_pkg.sv
// Shared constants for the multi-channel breathing PWM: channel modes and ramp states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_breath_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_ON     = 2'b01;
    localparam logic [1:0] MODE_BREATH = 2'b10;
    localparam logic [1:0] MODE_ANTI   = 2'b11;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } ramp_state_t;

    // Counter width for a 0..n-1 counter; a divide-by-1 still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared time base: 1 us prescaler, PWM period counter, ramp divider and triangular level FSM.
// Latency: combinational strobes (wrap/step) qualify the current counter values.
// Backpressure: none; free-running while en is high, cleared while en is low.
module pwm_timebase
    import pwm_breath_pkg::*;
#(
    parameter int CLK_MHZ  = 5,
    parameter int STEPS    = 1000,
    parameter int RAMP_DIV = 1,
    parameter int CW       = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] us_cnt,
    output logic [CW-1:0] level,
    output logic          wrap,
    output logic          step,
    output logic          period_start,
    output logic          ramp_bottom
);

    localparam int PW = cnt_w(CLK_MHZ);
    localparam int DW = cnt_w(RAMP_DIV);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    logic [PW-1:0] pre_cnt;
    logic [DW-1:0] div_cnt;
    logic          us_tick;
    ramp_state_t   state;
    ramp_state_t   state_nx;
    logic [CW-1:0] level_nx;

    assign us_tick      = en && (pre_cnt == PW'(CLK_MHZ - 1));
    assign wrap         = us_tick && (us_cnt == LAST);
    assign step         = wrap && (div_cnt == DW'(RAMP_DIV - 1));
    assign period_start = en && (pre_cnt == '0) && (us_cnt == '0);
    assign ramp_bottom  = (state == DOWN) && (level == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
            div_cnt <= '0;
        end else if (!en) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
            div_cnt <= '0;
        end else begin
            pre_cnt <= us_tick ? '0 : pre_cnt + PW'(1);
            if (us_tick) begin
                us_cnt <= wrap ? '0 : us_cnt + CW'(1);
            end
            if (wrap) begin
                div_cnt <= step ? '0 : div_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UP;
            level <= '0;
        end else if (!en) begin
            state <= UP;
            level <= '0;
        end else begin
            state <= state_nx;
            level <= level_nx;
        end
    end

    // Turning points hold the level for one extra step so each extreme is shown twice.
    always_comb begin
        state_nx = state;
        level_nx = level;
        if (step) begin
            case (state)
                UP: begin
                    if (level == LAST) state_nx = DOWN;
                    else               level_nx = level + CW'(1);
                end
                DOWN: begin
                    if (level == '0) state_nx = UP;
                    else             level_nx = level - CW'(1);
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_breath_multi.sv
// Multi-channel breathing LED PWM: per-channel off/on/breathe/antiphase over a shared time base.
// Latency: outputs registered one clk after the counter/level/mode values they reflect.
// Backpressure: none; en low clears the time base and forces outputs low on the next edge.
module pwm_breath_multi
    import pwm_breath_pkg::*;
#(
    parameter int CLK_MHZ  = 5,
    parameter int STEPS    = 1000,
    parameter int RAMP_DIV = 1,
    parameter int CH       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [2*CH-1:0] mode,
    output logic [CH-1:0]   pwm_sig,
    output logic            period_tick,
    output logic            breath_done
);

    localparam int CW = $clog2(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    logic [CW-1:0] us_cnt;
    logic [CW-1:0] level;
    logic [CW-1:0] anti_level;
    logic          wrap;
    logic          step;
    logic          period_start;
    logic          ramp_bottom;
    logic [CH-1:0] hit;

    pwm_timebase #(
        .CLK_MHZ  (CLK_MHZ),
        .STEPS    (STEPS),
        .RAMP_DIV (RAMP_DIV),
        .CW       (CW)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .us_cnt       (us_cnt),
        .level        (level),
        .wrap         (wrap),
        .step         (step),
        .period_start (period_start),
        .ramp_bottom  (ramp_bottom)
    );

    assign anti_level = LAST - level;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [1:0] mode_q;
        logic       ch_hit;

        // Mode only changes at a period boundary so no period is cut short or stretched.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_q <= MODE_OFF;
            end else if (!en || wrap) begin
                mode_q <= mode[2*i +: 2];
            end
        end

        always_comb begin
            ch_hit = 1'b0;
            case (mode_q)
                MODE_OFF:    ch_hit = 1'b0;
                MODE_ON:     ch_hit = 1'b1;
                MODE_BREATH: ch_hit = (us_cnt < level);
                MODE_ANTI:   ch_hit = (us_cnt < anti_level);
            endcase
        end

        assign hit[i] = ch_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_sig     <= '0;
            period_tick <= 1'b0;
            breath_done <= 1'b0;
        end else begin
            pwm_sig     <= en ? hit : '0;
            period_tick <= period_start;
            breath_done <= step && ramp_bottom;
        end
    end

endmodule

// File: tb/tb_pwm_breath_multi.sv
// Bench for pwm_breath_multi: directed scenarios plus random mode/enable traffic, two ramp dividers.
module tb_pwm_breath_multi;

    localparam int C   = 5;
    localparam int S   = 4;
    localparam int CH  = 4;
    localparam int PER = C * S;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic [2*CH-1:0] mode = '0;
    logic [CH-1:0]   pwm_a, pwm_b;
    logic            pt_a, pt_b, bd_a, bd_b;

    always #5 clk = ~clk;

    pwm_breath_multi #(.CLK_MHZ(C), .STEPS(S), .RAMP_DIV(1), .CH(CH)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .pwm_sig(pwm_a), .period_tick(pt_a), .breath_done(bd_a)
    );

    pwm_breath_multi #(.CLK_MHZ(C), .STEPS(S), .RAMP_DIV(2), .CH(CH)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .pwm_sig(pwm_b), .period_tick(pt_b), .breath_done(bd_b)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;                 // active cycles since the last restart
    logic [1:0] mode_m [CH];   // mode each channel is currently showing
    int hi_a [CH];
    int hi_b [CH];
    int bdc_a = 0;
    int bdc_b = 0;
    int tbl_a [8]  = '{0, 5, 10, 15, 15, 10, 5, 0};
    int tbl_b [16] = '{0, 0, 5, 5, 10, 10, 15, 15, 15, 15, 10, 10, 5, 5, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Triangle: k counts ramp steps within a breath of 2*S steps.
    function automatic int level_of(input int nn, input int r);
        int k;
        k = ((nn / PER) / r) % (2 * S);
        return (k < S) ? k : (2 * S - 1 - k);
    endfunction

    function automatic logic [CH-1:0] pwm_of(input int nn, input int r);
        int us, lv;
        logic [CH-1:0] v;
        us = (nn / C) % S;
        lv = level_of(nn, r);
        v  = '0;
        for (int i = 0; i < CH; i++) begin
            case (mode_m[i])
                2'd0:    v[i] = 1'b0;
                2'd1:    v[i] = 1'b1;
                2'd2:    v[i] = (us < lv);
                default: v[i] = (us < (S - 1 - lv));
            endcase
        end
        return v;
    endfunction

    task automatic cyc();
        logic [CH-1:0] ea, eb;
        logic ept, ebda, ebdb, last;
        ea = '0; eb = '0; ept = 1'b0; ebda = 1'b0; ebdb = 1'b0; last = 1'b0;
        if (en) begin
            ea   = pwm_of(n, 1);
            eb   = pwm_of(n, 2);
            ept  = ((n % PER) == 0);
            last = ((n % PER) == PER - 1);
            ebda = last && ((((n / PER) + 1) % (2 * S)) == 0);
            ebdb = last && ((((n / PER) + 1) % (4 * S)) == 0);
        end
        @(posedge clk);
        #1;
        chk("pwm_a", pwm_a, ea);
        chk("pwm_b", pwm_b, eb);
        chk("period_tick_a", pt_a, ept);
        chk("period_tick_b", pt_b, ept);
        chk("breath_done_a", bd_a, ebda);
        chk("breath_done_b", bd_b, ebdb);
        for (int i = 0; i < CH; i++) begin
            hi_a[i] += int'(pwm_a[i]);
            hi_b[i] += int'(pwm_b[i]);
        end
        bdc_a += int'(bd_a);
        bdc_b += int'(bd_b);
        if (!en) begin
            n = 0;
            for (int i = 0; i < CH; i++) mode_m[i] = mode[2*i +: 2];
        end else begin
            if (last) for (int i = 0; i < CH; i++) mode_m[i] = mode[2*i +: 2];
            n++;
        end
    endtask

    task automatic run_cycles(input int k);
        for (int i = 0; i < CH; i++) begin
            hi_a[i] = 0;
            hi_b[i] = 0;
        end
        repeat (k) cyc();
    endtask

    initial begin
        for (int i = 0; i < CH; i++) mode_m[i] = 2'b00;
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 8'hAA;
        #23;
        chk("rst_pwm", pwm_a, 0);
        chk("rst_period_tick", pt_a, 0);
        chk("rst_breath_done", bd_a, 0);
        rst_n = 1'b1;

        // Full breath with every channel breathing.
        bdc_a = 0;
        for (int p = 0; p < 8; p++) begin
            run_cycles(PER);
            chk($sformatf("s1_hi_p%0d", p), hi_a[0], tbl_a[p]);
        end
        chk("s1_breath_done_cnt", bdc_a, 1);

        // Mixed modes shown in the level-2 period.
        run_cycles(PER);
        mode = {2'b11, 2'b10, 2'b01, 2'b00};
        run_cycles(PER);
        run_cycles(PER);
        chk("s2_ch0_off", hi_a[0], 0);
        chk("s2_ch1_on", hi_a[1], 20);
        chk("s2_ch2_breath", hi_a[2], 10);
        chk("s2_ch3_anti", hi_a[3], 5);

        // Mid-period mode change waits for the next period.
        run_cycles(7);
        mode[1:0] = 2'b01;
        run_cycles(PER - 7);
        chk("s3_ch0_held_off", hi_a[0], 0);
        run_cycles(PER);
        chk("s3_ch0_on_next", hi_a[0], 20);

        // Enable dropped for three cycles mid-ramp.
        run_cycles(8);
        en = 1'b0;
        cyc();
        chk("s4_en_low_pwm", pwm_a, 0);
        cyc();
        cyc();
        en = 1'b1;
        run_cycles(PER);
        chk("s4_restart_ch0", hi_a[0], 20);
        chk("s4_restart_ch2", hi_a[2], 0);
        chk("s4_restart_ch3", hi_a[3], 15);

        // Asynchronous reset pulse mid-period.
        run_cycles(9);
        chk("s5_pre_rst_on", pwm_a[1], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_pwm_a", pwm_a, 0);
        chk("s5_rst_pwm_b", pwm_b, 0);
        chk("s5_rst_period_tick", pt_a, 0);
        chk("s5_rst_breath_done", bd_a, 0);
        @(posedge clk);
        #1;
        chk("s5_rst_hold_pwm", pwm_a, 0);
        mode = 8'hAA;
        #2;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < CH; i++) mode_m[i] = 2'b00;
        bdc_a = 0;
        bdc_b = 0;
        for (int p = 0; p < 16; p++) begin
            run_cycles(PER);
            chk($sformatf("s5_hi_a_p%0d", p), hi_a[0], tbl_a[p % 8]);
            chk($sformatf("s6_hi_b_p%0d", p), hi_b[0], tbl_b[p]);
        end
        chk("s5_breath_done_a_cnt", bdc_a, 2);
        chk("s6_breath_done_b_cnt", bdc_b, 1);

        // Random mode and enable traffic against the model.
        for (int it = 0; it < 40; it++) begin
            mode = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 4)) cyc();
                en = 1'b1;
            end
            repeat ($urandom_range(1, 40)) cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
